// File: rtl/int_rs_exec.sv
// -----------------------------------------------------------------------------
// int_rs_exec
//   Integer reservation station with a single-cycle ALU behind it.
//   Renamed uops are buffered until both source operands are available.
//   Operands become available through dispatch-time status or through CDB tag
//   broadcasts. One ready uop issues per cycle. The issuing uop reads its
//   operands from the PRF over a combinational port. The ALU result and the uop
//   tags are registered onto this unit's CDB lane at the issue edge.
//
//   Timing: a uop accepted at edge N with ready operands issues during cycle
//   N+1. Its result is presented on fu_cdb_* for one cycle after edge N+1.
//
// Configuration macro: INT_RS_AGE_PRIORITY_EN
//   defined   : issue picks the oldest ready entry, tracked by an age matrix
//   undefined : issue picks the lowest-index ready entry
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   id_*              dispatch handshake and renamed uop fields
//   id_ready          high while at least one entry is free
//   prf_rs*_phy       PRF read addresses of the issuing uop (0 when idle)
//   prf_rs*_value     combinational PRF read data
//   cdb_valid/rd_phy  snooped CDB lanes used for operand wakeup
//   fu_cdb_*          registered result broadcast of this unit
// -----------------------------------------------------------------------------
module int_rs_exec #(
    parameter int RS_DEPTH  = 8,
    parameter int XLEN      = 32,
    parameter int PRF_IDX_W = 6,
    parameter int ROB_IDX_W = 5,
    parameter int CDB_WIDTH = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    // dispatch
    input  logic                            id_valid,
    output logic                            id_ready,
    input  logic [XLEN-1:0]                 id_pc,
    input  logic [3:0]                      id_fu_opcode,
    input  logic                            id_op1_sel,
    input  logic                            id_op2_sel,
    input  logic [PRF_IDX_W-1:0]            id_rd_phy,
    input  logic [PRF_IDX_W-1:0]            id_rs1_phy,
    input  logic [PRF_IDX_W-1:0]            id_rs2_phy,
    input  logic                            id_rs1_valid,
    input  logic                            id_rs2_valid,
    input  logic [XLEN-1:0]                 id_imm,
    input  logic [ROB_IDX_W-1:0]            id_rob_id,
    input  logic [4:0]                      id_rd_arch,
    // PRF read port
    output logic [PRF_IDX_W-1:0]            prf_rs1_phy,
    output logic [PRF_IDX_W-1:0]            prf_rs2_phy,
    input  logic [XLEN-1:0]                 prf_rs1_value,
    input  logic [XLEN-1:0]                 prf_rs2_value,
    // snooped CDB
    input  logic [CDB_WIDTH-1:0]            cdb_valid,
    input  logic [CDB_WIDTH*PRF_IDX_W-1:0]  cdb_rd_phy,
    // result broadcast
    output logic                            fu_cdb_valid,
    output logic [ROB_IDX_W-1:0]            fu_cdb_rob_id,
    output logic [PRF_IDX_W-1:0]            fu_cdb_rd_phy,
    output logic [4:0]                      fu_cdb_rd_arch,
    output logic [XLEN-1:0]                 fu_cdb_rd_value
);

    localparam int IDX_W   = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
    localparam int SHAMT_W = $clog2(XLEN);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;

    // True when any valid CDB lane carries the given tag.
    function automatic logic cdb_hit(
        input logic [CDB_WIDTH-1:0]           vld,
        input logic [CDB_WIDTH*PRF_IDX_W-1:0] tags,
        input logic [PRF_IDX_W-1:0]           tag
    );
        logic hit;
        hit = 1'b0;
        for (int l = 0; l < CDB_WIDTH; l++) begin
            if (vld[l] && (tags[l*PRF_IDX_W +: PRF_IDX_W] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Single-cycle integer ALU; unknown opcodes produce zero.
    function automatic logic [XLEN-1:0] alu_op(
        input logic [3:0]      op,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        logic [SHAMT_W-1:0]     sh;
        logic [XLEN-1:0]        res;
        sa = a;
        sb = b;
        sh = b[SHAMT_W-1:0];
        case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_SLL:  res = a << sh;
            OP_SLT:  res = {{(XLEN-1){1'b0}}, (sa < sb)};
            OP_SLTU: res = {{(XLEN-1){1'b0}}, (a < b)};
            OP_XOR:  res = a ^ b;
            OP_SRL:  res = a >> sh;
            OP_SRA:  res = sa >>> sh;
            OP_OR:   res = a | b;
            OP_AND:  res = a & b;
            default: res = '0;
        endcase
        return res;
    endfunction

    // Entry storage: control bits are reset, payload is only written on dispatch.
    logic [RS_DEPTH-1:0]  ent_valid;
    logic [RS_DEPTH-1:0]  ent_rdy1;
    logic [RS_DEPTH-1:0]  ent_rdy2;
    logic [RS_DEPTH-1:0]  ent_op1_sel;
    logic [RS_DEPTH-1:0]  ent_op2_sel;
    logic [3:0]           ent_op      [RS_DEPTH];
    logic [XLEN-1:0]      ent_pc      [RS_DEPTH];
    logic [XLEN-1:0]      ent_imm     [RS_DEPTH];
    logic [PRF_IDX_W-1:0] ent_rd_phy  [RS_DEPTH];
    logic [PRF_IDX_W-1:0] ent_rs1_phy [RS_DEPTH];
    logic [PRF_IDX_W-1:0] ent_rs2_phy [RS_DEPTH];
    logic [ROB_IDX_W-1:0] ent_rob     [RS_DEPTH];
    logic [4:0]           ent_rd_arch [RS_DEPTH];

    logic             full;
    logic             dispatch;
    logic [IDX_W-1:0] free_idx;
    logic             id_rdy1;
    logic             id_rdy2;

    logic [RS_DEPTH-1:0] rdy_vec_p0;
    logic [RS_DEPTH-1:0] iss_mask_p0;
    logic                iss_vld_p0;
    logic [IDX_W-1:0]    iss_idx_p0;
    logic [XLEN-1:0]     op1_p0;
    logic [XLEN-1:0]     op2_p0;
    logic [XLEN-1:0]     result_p0;

    // ---- dispatch stage ----
    // No credit is given for an entry that issues this cycle, so a full
    // station stays closed until the freed slot is visible.
    assign full     = &ent_valid;
    assign id_ready = !full;
    assign dispatch = id_valid && id_ready;

    always_comb begin
        free_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!ent_valid[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    // An operand is pending only when it comes from a register, is not yet
    // written, and is not the hardwired zero register. A broadcast in the
    // dispatch cycle counts as already written.
    assign id_rdy1 = id_op1_sel || id_rs1_valid || (id_rs1_phy == '0) ||
                     cdb_hit(cdb_valid, cdb_rd_phy, id_rs1_phy);
    assign id_rdy2 = id_op2_sel || id_rs2_valid || (id_rs2_phy == '0) ||
                     cdb_hit(cdb_valid, cdb_rd_phy, id_rs2_phy);

    // ---- issue stage (p0) ----
    assign rdy_vec_p0 = ent_valid & ent_rdy1 & ent_rdy2;

`ifdef INT_RS_AGE_PRIORITY_EN
    // older_than[i] holds the entries dispatched before entry i that were
    // still resident at that time. A reused slot clears its column so that
    // stale history never makes a fresh entry look old.
    logic [RS_DEPTH-1:0] older_than [RS_DEPTH];

    always_ff @(posedge clk) begin
        if (dispatch) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                older_than[i][free_idx] <= 1'b0;
            end
            older_than[free_idx] <= ent_valid & ~iss_mask_p0;
        end
    end

    always_comb begin
        iss_vld_p0 = 1'b0;
        iss_idx_p0 = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (rdy_vec_p0[i] && ((rdy_vec_p0 & older_than[i]) == '0)) begin
                iss_vld_p0 = 1'b1;
                iss_idx_p0 = IDX_W'(i);
            end
        end
    end
`else
    always_comb begin
        iss_vld_p0 = 1'b0;
        iss_idx_p0 = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (rdy_vec_p0[i]) begin
                iss_vld_p0 = 1'b1;
                iss_idx_p0 = IDX_W'(i);
            end
        end
    end
`endif

    always_comb begin
        iss_mask_p0 = '0;
        if (iss_vld_p0) begin
            iss_mask_p0[iss_idx_p0] = 1'b1;
        end
    end

    assign prf_rs1_phy = iss_vld_p0 ? ent_rs1_phy[iss_idx_p0] : '0;
    assign prf_rs2_phy = iss_vld_p0 ? ent_rs2_phy[iss_idx_p0] : '0;

    assign op1_p0    = ent_op1_sel[iss_idx_p0] ? ent_pc[iss_idx_p0]  : prf_rs1_value;
    assign op2_p0    = ent_op2_sel[iss_idx_p0] ? ent_imm[iss_idx_p0] : prf_rs2_value;
    assign result_p0 = alu_op(ent_op[iss_idx_p0], op1_p0, op2_p0);

    // ---- result stage (p1): entry state and CDB registers ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            ent_valid       <= '0;
            ent_rdy1        <= '0;
            ent_rdy2        <= '0;
            fu_cdb_valid    <= 1'b0;
            fu_cdb_rob_id   <= '0;
            fu_cdb_rd_phy   <= '0;
            fu_cdb_rd_arch  <= '0;
            fu_cdb_rd_value <= '0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (ent_valid[i] && !ent_rdy1[i] &&
                    cdb_hit(cdb_valid, cdb_rd_phy, ent_rs1_phy[i])) begin
                    ent_rdy1[i] <= 1'b1;
                end
                if (ent_valid[i] && !ent_rdy2[i] &&
                    cdb_hit(cdb_valid, cdb_rd_phy, ent_rs2_phy[i])) begin
                    ent_rdy2[i] <= 1'b1;
                end
            end
            if (iss_vld_p0) begin
                ent_valid[iss_idx_p0] <= 1'b0;
            end
            // free_idx is never the issuing slot, so these cannot collide.
            if (dispatch) begin
                ent_valid[free_idx] <= 1'b1;
                ent_rdy1[free_idx]  <= id_rdy1;
                ent_rdy2[free_idx]  <= id_rdy2;
            end
            fu_cdb_valid    <= iss_vld_p0;
            fu_cdb_rob_id   <= iss_vld_p0 ? ent_rob[iss_idx_p0]     : '0;
            fu_cdb_rd_phy   <= iss_vld_p0 ? ent_rd_phy[iss_idx_p0]  : '0;
            fu_cdb_rd_arch  <= iss_vld_p0 ? ent_rd_arch[iss_idx_p0] : '0;
            fu_cdb_rd_value <= iss_vld_p0 ? result_p0               : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (dispatch) begin
            ent_op1_sel[free_idx] <= id_op1_sel;
            ent_op2_sel[free_idx] <= id_op2_sel;
            ent_op[free_idx]      <= id_fu_opcode;
            ent_pc[free_idx]      <= id_pc;
            ent_imm[free_idx]     <= id_imm;
            ent_rd_phy[free_idx]  <= id_rd_phy;
            ent_rs1_phy[free_idx] <= id_rs1_phy;
            ent_rs2_phy[free_idx] <= id_rs2_phy;
            ent_rob[free_idx]     <= id_rob_id;
            ent_rd_arch[free_idx] <= id_rd_arch;
        end
    end

endmodule

// File: tb/tb_int_rs_exec.sv
// -----------------------------------------------------------------------------
// tb_int_rs_exec
//   Directed bench for int_rs_exec. Stimulus pushes the expected CDB result
//   (tags, value and the cycle it must appear in) into a scoreboard queue; a
//   monitor pops and compares each time fu_cdb_valid is seen.
// -----------------------------------------------------------------------------
module tb_int_rs_exec;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [3:0]  id_fu_opcode;
    logic        id_op1_sel;
    logic        id_op2_sel;
    logic [5:0]  id_rd_phy;
    logic [5:0]  id_rs1_phy;
    logic [5:0]  id_rs2_phy;
    logic        id_rs1_valid;
    logic        id_rs2_valid;
    logic [31:0] id_imm;
    logic [4:0]  id_rob_id;
    logic [4:0]  id_rd_arch;
    logic [5:0]  prf_rs1_phy;
    logic [5:0]  prf_rs2_phy;
    logic [31:0] prf_rs1_value;
    logic [31:0] prf_rs2_value;
    logic [1:0]  cdb_valid;
    logic [11:0] cdb_rd_phy;
    logic        fu_cdb_valid;
    logic [4:0]  fu_cdb_rob_id;
    logic [5:0]  fu_cdb_rd_phy;
    logic [4:0]  fu_cdb_rd_arch;
    logic [31:0] fu_cdb_rd_value;

    logic [31:0] prf [64];
    int          cyc;
    int          checks;
    int          failures;

    typedef struct {
        logic [4:0]  rob;
        logic [5:0]  rd;
        logic [4:0]  arch;
        logic [31:0] val;
        int          at;
    } exp_t;
    exp_t sb[$];

    int_rs_exec dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_pc           (id_pc),
        .id_fu_opcode    (id_fu_opcode),
        .id_op1_sel      (id_op1_sel),
        .id_op2_sel      (id_op2_sel),
        .id_rd_phy       (id_rd_phy),
        .id_rs1_phy      (id_rs1_phy),
        .id_rs2_phy      (id_rs2_phy),
        .id_rs1_valid    (id_rs1_valid),
        .id_rs2_valid    (id_rs2_valid),
        .id_imm          (id_imm),
        .id_rob_id       (id_rob_id),
        .id_rd_arch      (id_rd_arch),
        .prf_rs1_phy     (prf_rs1_phy),
        .prf_rs2_phy     (prf_rs2_phy),
        .prf_rs1_value   (prf_rs1_value),
        .prf_rs2_value   (prf_rs2_value),
        .cdb_valid       (cdb_valid),
        .cdb_rd_phy      (cdb_rd_phy),
        .fu_cdb_valid    (fu_cdb_valid),
        .fu_cdb_rob_id   (fu_cdb_rob_id),
        .fu_cdb_rd_phy   (fu_cdb_rd_phy),
        .fu_cdb_rd_arch  (fu_cdb_rd_arch),
        .fu_cdb_rd_value (fu_cdb_rd_value)
    );

    assign prf_rs1_value = prf[prf_rs1_phy];
    assign prf_rs2_value = prf[prf_rs2_phy];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (fu_cdb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL cdb_unexpected actual=rob %0h value %0h required=no result at cycle %0d",
                         fu_cdb_rob_id, fu_cdb_rd_value, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("cdb_cycle", 64'(cyc), 64'(e.at));
                check("cdb_rob_id", 64'(fu_cdb_rob_id), 64'(e.rob));
                check("cdb_rd_phy", 64'(fu_cdb_rd_phy), 64'(e.rd));
                check("cdb_rd_arch", 64'(fu_cdb_rd_arch), 64'(e.arch));
                check("cdb_value", 64'(fu_cdb_rd_value), 64'(e.val));
            end
        end
    end

    initial begin
        repeat (5000) @(posedge clk);
        $display("FAIL watchdog actual=no finish required=finish within 5000 cycles");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_in();
        id_valid   = 1'b0;
        cdb_valid  = 2'b00;
        cdb_rd_phy = '0;
    endtask

    task automatic set_cdb(input logic [1:0] v, input logic [5:0] t0, input logic [5:0] t1);
        cdb_valid  = v;
        cdb_rd_phy = {t1, t0};
    endtask

    task automatic drive_uop(input logic [3:0] op, input logic s1, input logic s2,
                             input logic [5:0] rd, input logic [5:0] rs1, input logic [5:0] rs2,
                             input logic v1, input logic v2, input logic [31:0] imm,
                             input logic [4:0] rob, input logic [4:0] arch, input logic [31:0] pc);
        id_valid     = 1'b1;
        id_fu_opcode = op;
        id_op1_sel   = s1;
        id_op2_sel   = s2;
        id_rd_phy    = rd;
        id_rs1_phy   = rs1;
        id_rs2_phy   = rs2;
        id_rs1_valid = v1;
        id_rs2_valid = v2;
        id_imm       = imm;
        id_rob_id    = rob;
        id_rd_arch   = arch;
        id_pc        = pc;
    endtask

    task automatic expect_at(input logic [4:0] rob, input logic [5:0] rd, input logic [4:0] arch,
                             input logic [31:0] val, input int at);
        exp_t e;
        e.rob  = rob;
        e.rd   = rd;
        e.arch = arch;
        e.val  = val;
        e.at   = at;
        sb.push_back(e);
    endtask

    // Ready-at-dispatch ALU vector, issued back to back with its neighbours.
    task automatic alu_vec(input logic [3:0] op, input logic s1, input logic s2,
                           input logic [5:0] rs1, input logic [5:0] rs2,
                           input logic [31:0] pc, input logic [31:0] imm,
                           input logic [31:0] res, input logic [4:0] rob);
        drive_uop(op, s1, s2, 6'(rob + 5'd20), rs1, rs2, 1'b1, 1'b1, imm, rob, rob, pc);
        expect_at(rob, 6'(rob + 5'd20), rob, res, cyc + 2);
        step();
    endtask

    initial begin
        int c;
        cyc      = 0;
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 64; i++) prf[i] = 32'h0;
        rst = 1'b0;
        clear_in();
        drive_uop(4'd0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0, '0);
        id_valid = 1'b0;

        // Reset state
        repeat (3) step();
        rst = 1'b1;
        step();
        check("rst_id_ready", 64'(id_ready), 64'd1);
        check("rst_cdb_valid", 64'(fu_cdb_valid), 64'd0);
        check("rst_cdb_value", 64'(fu_cdb_rd_value), 64'd0);
        check("rst_cdb_rob", 64'(fu_cdb_rob_id), 64'd0);
        check("rst_prf_addr", 64'(prf_rs1_phy), 64'd0);

        // 1: ready ADD rs1(phy2)=0 + imm 1
        drive_uop(4'd0, 1'b0, 1'b1, 6'd1, 6'd2, 6'd0, 1'b1, 1'b0, 32'd1, 5'd0, 5'd1, 32'h0);
        expect_at(5'd0, 6'd1, 5'd1, 32'd1, cyc + 2);
        step();
        clear_in();
        check("t1_issue_addr", 64'(prf_rs1_phy), 64'd2);
        step();
        check("t1_idle_addr", 64'(prf_rs1_phy), 64'd0);

        // 2: wait on phy5, woken by lane 1
        prf[5] = 32'd7;
        drive_uop(4'd0, 1'b0, 1'b1, 6'd3, 6'd5, 6'd0, 1'b0, 1'b0, 32'd1, 5'd1, 5'd3, 32'h0);
        step();
        clear_in();
        check("t2_wait_addr", 64'(prf_rs1_phy), 64'd0);
        repeat (2) step();
        set_cdb(2'b10, 6'd0, 6'd5);
        expect_at(5'd1, 6'd3, 5'd3, 32'd8, cyc + 2);
        step();
        clear_in();
        repeat (3) step();

        // 3: fill the station with waiting uops (entry i waits on tag 10+i)
        for (int i = 10; i < 18; i++) prf[i] = 32'(3 * i);
        for (int i = 0; i < 8; i++) begin
            drive_uop(4'd0, 1'b0, 1'b1, 6'(20 + i), 6'(10 + i), 6'd0, 1'b0, 1'b0,
                      32'(i), 5'(2 + i), 5'(1 + i), 32'h0);
            step();
        end
        clear_in();
        check("t3_full_ready", 64'(id_ready), 64'd0);
        set_cdb(2'b10, 6'd0, 6'd12);
        expect_at(5'd4, 6'd22, 5'd3, 32'd38, cyc + 2);
        step();
        clear_in();
        check("t3_no_credit", 64'(id_ready), 64'd0);
        check("t3_issue_addr", 64'(prf_rs1_phy), 64'd12);
        step();
        check("t3_freed_ready", 64'(id_ready), 64'd1);
        // drain the rest; results at one per cycle in entry order
        c = cyc;
        for (int i = 0; i < 8; i++) begin
            if (i != 2) begin
                expect_at(5'(2 + i), 6'(20 + i), 5'(1 + i), 32'(30 + 4 * i),
                          c + ((i < 2) ? i + 2 : i + 1));
            end
        end
        set_cdb(2'b11, 6'd10, 6'd11);
        step();
        set_cdb(2'b11, 6'd13, 6'd14);
        step();
        set_cdb(2'b11, 6'd15, 6'd16);
        step();
        set_cdb(2'b01, 6'd17, 6'd0);
        step();
        clear_in();
        repeat (6) step();

        // 4: bypass wakeup on the dispatch cycle
        prf[9] = 32'd40;
        drive_uop(4'd0, 1'b0, 1'b1, 6'd40, 6'd9, 6'd0, 1'b0, 1'b0, 32'd2, 5'd12, 5'd9, 32'h0);
        set_cdb(2'b10, 6'd0, 6'd9);
        expect_at(5'd12, 6'd40, 5'd9, 32'd42, cyc + 2);
        step();
        clear_in();
        check("t4_bypass_addr", 64'(prf_rs1_phy), 64'd9);
        step();

        // 5: ALU corner cases, back to back
        prf[7] = 32'hFF00FF00;
        prf[6] = 32'h0FF00FF0;
        alu_vec(4'd1, 1'b0, 1'b1, 6'd0, 6'd0, 32'h0,        32'h1,        32'hFFFFFFFF, 5'd13);
        alu_vec(4'd7, 1'b1, 1'b1, 6'd0, 6'd0, 32'h80000000, 32'h4,        32'hF8000000, 5'd14);
        alu_vec(4'd4, 1'b1, 1'b1, 6'd0, 6'd0, 32'h1,        32'hFFFFFFFF, 32'h1,        5'd15);
        alu_vec(4'd0, 1'b1, 1'b1, 6'd0, 6'd0, 32'h1000,     32'h24,       32'h1024,     5'd16);
        alu_vec(4'd3, 1'b1, 1'b1, 6'd0, 6'd0, 32'hFFFFFFFF, 32'h1,        32'h1,        5'd17);
        alu_vec(4'd3, 1'b1, 1'b1, 6'd0, 6'd0, 32'h1,        32'hFFFFFFFF, 32'h0,        5'd18);
        alu_vec(4'd2, 1'b1, 1'b1, 6'd0, 6'd0, 32'h1,        32'h24,       32'h10,       5'd19);
        alu_vec(4'd6, 1'b1, 1'b1, 6'd0, 6'd0, 32'h80000000, 32'h4,        32'h08000000, 5'd20);
        alu_vec(4'd5, 1'b1, 1'b1, 6'd0, 6'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 5'd21);
        alu_vec(4'd8, 1'b1, 1'b1, 6'd0, 6'd0, 32'hF0000000, 32'hF,        32'hF000000F, 5'd22);
        alu_vec(4'd9, 1'b0, 1'b0, 6'd7, 6'd6, 32'h0,        32'h0,        32'h0F000F00, 5'd23);
        alu_vec(4'd15, 1'b1, 1'b1, 6'd0, 6'd0, 32'h5,       32'h6,        32'h0,        5'd24);
        alu_vec(4'd0, 1'b1, 1'b1, 6'd0, 6'd0, 32'hFFFFFFFF, 32'h2,        32'h1,        5'd25);
        clear_in();
        repeat (4) step();

        // 6: reset with three waiting entries
        for (int i = 0; i < 3; i++) begin
            drive_uop(4'd0, 1'b0, 1'b1, 6'(50 + i), 6'(30 + i), 6'd0, 1'b0, 1'b0,
                      32'd1, 5'(26 + i), 5'd7, 32'h0);
            step();
        end
        clear_in();
        check("t6_pre_ready", 64'(id_ready), 64'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("t6_rst_ready", 64'(id_ready), 64'd1);
        check("t6_rst_cdb_valid", 64'(fu_cdb_valid), 64'd0);
        set_cdb(2'b11, 6'd30, 6'd31);
        step();
        check("t6_no_issue_a", 64'(prf_rs1_phy), 64'd0);
        set_cdb(2'b10, 6'd0, 6'd32);
        step();
        clear_in();
        check("t6_no_issue_b", 64'(prf_rs1_phy), 64'd0);
        repeat (4) step();

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
